seg_time_ctrl: RTL

Time-of-day display and set controller that sits directly upstream of the six-digit seven-segment BCD display stage. It latches BCD time samples from the DS1302 reader and drives the display stage's BCD word, per-digit blank masks and decimal-point masks. It also runs a key-driven HH/MM/SS edit mode with a blinking selected field, and hands the edited time to the DS1302 writer over a req/ack handshake.

---
 rtl/seg_time_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_time_ctrl.sv
// Time-of-day display/set controller: latches DS1302 BCD samples for the display,
// runs the key-driven HH/MM/SS edit FSM with a blinking field, and commits edits to the writer.
module seg_time_ctrl #(
  parameter int unsigned BLINK_HALF_CYC = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rtc_time,
  input  logic        rtc_valid,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        disp_off,
  output logic [23:0] seg_bcd,
  output logic [7:0]  en_all,
  output logic [7:0]  en_0,
  output logic [7:0]  en_1,
  output logic [7:0]  en_2,
  output logic [7:0]  en_3,
  output logic [7:0]  en_4,
  output logic [7:0]  en_5,
  output logic [7:0]  dp_0,
  output logic [7:0]  dp_1,
  output logic        wr_req,
  output logic [23:0] wr_time,
  input  logic        wr_ack,
  output logic        setting
);

  localparam int CW = (BLINK_HALF_CYC > 2) ? $clog2(BLINK_HALF_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF_CYC - 1);

  typedef enum logic [2:0] {RUN, SET_HH, SET_MM, SET_SS, COMMIT} state_t;

  // Illegal fields (bad nibble or out of range) go to 00 when stepped up.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Illegal fields go to max when stepped down.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max || v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] bcd_adj(input logic [7:0] v, input logic [7:0] max,
                                         input logic up);
    return up ? bcd_inc(v, max) : bcd_dec(v, max);
  endfunction

  state_t         state_q, state_d;
  logic [23:0]    edit_q, edit_d;
  logic [23:0]    seg_q, seg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           phase_q, phase_d;
  logic [5:0]     blank_q, blank_d;
  logic           dp_lit_q, dp_lit_d;
  logic           off_q;
  logic           wr_req_q;
  logic [23:0]    wr_time_q;
  logic           setting_q;
  logic           key_any, adj;

  assign key_any = key_mode | key_up | key_down;
  assign adj     = key_up ^ key_down;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    edit_d  = edit_q;
    seg_d   = seg_q;
    case (state_q)
      RUN: begin
        if (key_mode) begin
          edit_d  = seg_q;
          state_d = SET_HH;
        end else if (rtc_valid) begin
          seg_d = rtc_time;
        end
      end
      SET_HH: begin
        if (key_mode)  state_d = SET_MM;
        else if (adj)  edit_d[23:16] = bcd_adj(edit_q[23:16], 8'h23, key_up);
        seg_d = edit_d;
      end
      SET_MM: begin
        if (key_mode)  state_d = SET_SS;
        else if (adj)  edit_d[15:8] = bcd_adj(edit_q[15:8], 8'h59, key_up);
        seg_d = edit_d;
      end
      SET_SS: begin
        if (key_mode)  state_d = COMMIT;
        else if (adj)  edit_d[7:0] = bcd_adj(edit_q[7:0], 8'h59, key_up);
        seg_d = edit_d;
      end
      COMMIT: begin
        if (wr_req_q && wr_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Any key restarts the blink so the field being adjusted stays visible.
    if (key_any) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
    end

    blank_d = 6'b0;
    case (state_d)
      SET_HH:  blank_d[1:0] = {2{phase_d}};
      SET_MM:  blank_d[3:2] = {2{phase_d}};
      SET_SS:  blank_d[5:4] = {2{phase_d}};
      default: blank_d = 6'b0;
    endcase

    dp_lit_d = (state_d == RUN) ? ~seg_d[0] : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      edit_q    <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      blank_q   <= '0;
      dp_lit_q  <= 1'b0;
      off_q     <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_time_q <= '0;
      setting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edit_q    <= edit_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      blank_q   <= blank_d;
      dp_lit_q  <= dp_lit_d;
      off_q     <= disp_off;
      wr_req_q  <= (state_d == COMMIT);
      wr_time_q <= (state_d == COMMIT) ? edit_d : wr_time_q;
      setting_q <= (state_d != RUN);
    end
  end

  assign seg_bcd = seg_q;
  assign en_all  = {8{off_q}};
  assign en_0    = {8{blank_q[0]}};
  assign en_1    = {8{blank_q[1]}};
  assign en_2    = {8{blank_q[2]}};
  assign en_3    = {8{blank_q[3]}};
  assign en_4    = {8{blank_q[4]}};
  assign en_5    = {8{blank_q[5]}};
  assign dp_0    = dp_lit_q ? 8'h7F : 8'hFF;
  assign dp_1    = dp_lit_q ? 8'h7F : 8'hFF;
  assign wr_req  = wr_req_q;
  assign wr_time = wr_time_q;
  assign setting = setting_q;

endmodule
